lcd_spi_rx_decoder: RTL and testbench

- Display-side responder for the 4-wire LCD SPI link (cs/dc/sclk/mosi) driven by the LCD write path.
- Oversamples the link in the system clock domain and deserialises it into 9-bit {dc,byte} words.
- Decodes CASET (0x2A), RASET (0x2B) and RAMWR (0x2C) into window registers and a stream of addressed RGB565 pixels.
- Used as an on-chip loopback monitor and as the bench-side display model for the LCD init and picture paths.

---
 rtl/lcd_spi_pkg.sv | 19 +
 rtl/lcd_spi_rx_decoder_deser.sv | 94 +++++++++
 rtl/lcd_spi_rx_decoder.sv | 159 +++++++++++++++
 tb/tb_lcd_spi_rx_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the LCD SPI receive decoder.
// Command codes, decoder states and coordinate width.
package lcd_spi_pkg;

  localparam int CW = 9;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    RASET,
    RAMWR,
    SKIP
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_rx_decoder_deser.sv
// Oversampling SPI deserialiser: synchronisers, sclk rise detect,
// MSB-first shifter, {dc,byte} words and partial-byte error pulse.
module lcd_spi_rx_decoder_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       dc,
  input  logic       sclk,
  input  logic       mosi,
  output logic       word_valid,
  output logic [8:0] word_data,
  output logic       err_partial
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic       cs_s;
  logic       dc_s;
  logic       sclk_s;
  logic       mosi_s;
  logic       sclk_prev;
  logic       rise;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       dc_q;
  logic       word_pend;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev & ~cs_s;

  // Bring the asynchronous link into the system clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      dc_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  // Shift bits on sclk rise; cs high drops any partial byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      dc_q        <= 1'b0;
      word_pend   <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      err_partial <= 1'b0;
      word_pend   <= 1'b0;
      if (cs_s) begin
        bit_cnt     <= '0;
        err_partial <= (bit_cnt != 3'd0);
      end else if (rise) begin
        shreg   <= {shreg[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          dc_q      <= dc_s;
          word_pend <= 1'b1;
        end
      end
    end
  end

  // Present the completed word one cycle after the last shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= word_pend;
      if (word_pend) begin
        word_data <= {dc_q, shreg};
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx_decoder.sv
// Display-side LCD SPI responder: decodes CASET/RASET/RAMWR into
// window registers and a stream of addressed RGB565 pixels.
module lcd_spi_rx_decoder
  import lcd_spi_pkg::*;
#(
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int SYNC_STAGES = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          spi_cs,
  input  logic          spi_dc,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  output logic          word_valid,
  output logic [8:0]    word_data,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic          pixel_valid,
  output logic [15:0]   pixel_data,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic [CW-1:0] win_xs,
  output logic [CW-1:0] win_xe,
  output logic [CW-1:0] win_ys,
  output logic [CW-1:0] win_ye,
  output logic          frame_done,
  output logic          err_partial
);

  localparam logic [CW-1:0] XE_RST = CW'(H_RES - 1);
  localparam logic [CW-1:0] YE_RST = CW'(V_RES - 1);

  dec_state_t    state;
  logic [1:0]    prm_cnt;
  logic          prm_hi;
  logic [CW-1:0] prm_start;
  logic [CW-1:0] prm_end;
  logic [CW-1:0] prm_end_c;
  logic          phase_lo;
  logic [7:0]    hi_byte;
  logic [CW-1:0] cur_x;
  logic [CW-1:0] cur_y;
  logic          wdc;
  logic [7:0]    wbyte;

  lcd_spi_rx_decoder_deser #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .cs         (spi_cs),
    .dc         (spi_dc),
    .sclk       (spi_sclk),
    .mosi       (spi_mosi),
    .word_valid (word_valid),
    .word_data  (word_data),
    .err_partial(err_partial)
  );

  assign wdc       = word_data[8];
  assign wbyte     = word_data[7:0];
  assign prm_end   = {prm_hi, wbyte};
  assign prm_end_c = (prm_end < prm_start) ? prm_start : prm_end;

  // Command FSM, window registers and pixel address counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      prm_cnt     <= '0;
      prm_hi      <= 1'b0;
      prm_start   <= '0;
      phase_lo    <= 1'b0;
      hi_byte     <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_done  <= 1'b0;
      win_xs      <= '0;
      win_xe      <= XE_RST;
      win_ys      <= '0;
      win_ye      <= YE_RST;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (word_valid) begin
        if (!wdc) begin
          cmd_valid <= 1'b1;
          cmd_code  <= wbyte;
          prm_cnt   <= '0;
          phase_lo  <= 1'b0;
          case (wbyte)
            CMD_CASET: state <= CASET;
            CMD_RASET: state <= RASET;
            CMD_RAMWR: begin
              state <= RAMWR;
              cur_x <= win_xs;
              cur_y <= win_ys;
            end
            default: state <= SKIP;
          endcase
        end else begin
          case (state)
            CASET, RASET: begin
              prm_cnt <= prm_cnt + 2'd1;
              case (prm_cnt)
                2'd0: prm_hi <= wbyte[0];
                2'd1: prm_start <= {prm_hi, wbyte};
                2'd2: prm_hi <= wbyte[0];
                default: begin
                  state <= IDLE;
                  if (state == CASET) begin
                    win_xs <= prm_start;
                    win_xe <= prm_end_c;
                  end else begin
                    win_ys <= prm_start;
                    win_ye <= prm_end_c;
                  end
                end
              endcase
            end
            RAMWR: begin
              if (!phase_lo) begin
                hi_byte  <= wbyte;
                phase_lo <= 1'b1;
              end else begin
                phase_lo    <= 1'b0;
                pixel_valid <= 1'b1;
                pixel_data  <= {hi_byte, wbyte};
                pixel_x     <= cur_x;
                pixel_y     <= cur_y;
                frame_done  <= (cur_x == win_xe) && (cur_y == win_ye);
                if (cur_x == win_xe) begin
                  cur_x <= win_xs;
                  if (cur_y == win_ye) begin
                    cur_y <= win_ys;
                  end else begin
                    cur_y <= cur_y + CW'(1);
                  end
                end else begin
                  cur_x <= cur_x + CW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// Randomised self-checking bench for lcd_spi_rx_decoder against a
// word-level behavioural model of the display command protocol.
module tb_lcd_spi_rx_decoder;

  localparam int S = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_dc = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        word_valid;
  logic [8:0]  word_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [8:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [8:0]  win_xs;
  logic [8:0]  win_xe;
  logic [8:0]  win_ys;
  logic [8:0]  win_ye;
  logic        frame_done;
  logic        err_partial;

  lcd_spi_rx_decoder #(
    .H_RES(240),
    .V_RES(320),
    .SYNC_STAGES(S)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .word_valid (word_valid),
    .word_data  (word_data),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .win_xs     (win_xs),
    .win_xe     (win_xe),
    .win_ys     (win_ys),
    .win_ye     (win_ye),
    .frame_done (frame_done),
    .err_partial(err_partial)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observation side
  int cyc = 0;
  int rise8 = 0;
  int n_cmd = 0;
  int n_err = 0;
  int n_word = 0;
  int n_fd = 0;
  int n_pulse = 0;
  int lat_q[$];
  logic [63:0] got_pix[$];
  logic [63:0] exp_pix[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (pixel_valid)
        got_pix.push_back(64'({frame_done, pixel_x, pixel_y, pixel_data}));
      if (cmd_valid) n_cmd++;
      if (err_partial) n_err++;
      if (frame_done) n_fd++;
      if (word_valid) begin
        n_word++;
        lat_q.push_back(cyc - rise8);
      end
      if (cmd_valid | pixel_valid | frame_done | err_partial | word_valid)
        n_pulse++;
    end
  end

  // Behavioural model: one call per complete word on the wire
  int m_xs, m_xe, m_ys, m_ye;
  int m_mode;
  int m_cnt;
  int m_p[4];
  int m_x, m_y;
  bit m_hi_have;
  int m_hi;
  int m_cmd;
  int m_ncmd = 0;
  int m_nfd = 0;

  task automatic model_reset();
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
    m_mode = 0; m_cnt = 0; m_hi_have = 0; m_cmd = 0;
    m_x = 0; m_y = 0; m_hi = 0;
  endtask

  task automatic model_word(input bit dc, input int b);
    int s, e;
    longint v;
    bit fd;
    if (!dc) begin
      m_cmd = b; m_ncmd++; m_hi_have = 0; m_cnt = 0;
      if (b == 'h2A) m_mode = 1;
      else if (b == 'h2B) m_mode = 2;
      else if (b == 'h2C) begin
        m_mode = 3; m_x = m_xs; m_y = m_ys;
      end else m_mode = 4;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_p[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 4) begin
        s = (m_p[0] * 256 + m_p[1]) % 512;
        e = (m_p[2] * 256 + m_p[3]) % 512;
        if (e < s) e = s;
        if (m_mode == 1) begin m_xs = s; m_xe = e; end
        else begin m_ys = s; m_ye = e; end
        m_mode = 0; m_cnt = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_hi_have) begin
        m_hi = b; m_hi_have = 1;
      end else begin
        m_hi_have = 0;
        fd = (m_x == m_xe) && (m_y == m_ye);
        if (fd) m_nfd++;
        v = (longint'(fd) << 34) | (longint'(m_x) << 25) |
            (longint'(m_y) << 16) | longint'(m_hi * 256 + b);
        exp_pix.push_back(64'(v));
        if (m_x == m_xe) begin
          m_x = m_xs;
          m_y = (m_y == m_ye) ? m_ys : m_y + 1;
        end else m_x++;
      end
    end
  endtask

  // Drive side
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bits(input bit dc, input logic [7:0] b,
                           input int nbits, input int half);
    spi_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      tick(half);
      spi_sclk = 1'b1;
      if (i == 7) rise8 = cyc;
      tick(half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input int b, input int half);
    send_bits(dc, 8'(b), 8, half);
    model_word(dc, b);
  endtask

  task automatic cs_on();
    spi_cs = 1'b0;
    tick(3);
  endtask

  task automatic cs_off();
    tick(3);
    spi_cs = 1'b1;
    tick(4);
  endtask

  task automatic check_pix(input string tag);
    int n;
    tick(S + 8);
    chk({tag, "_npix"}, 64'(got_pix.size()), 64'(exp_pix.size()));
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) chk(tag, got_pix[i], exp_pix[i]);
    got_pix.delete();
    exp_pix.delete();
  endtask

  task automatic check_win(input string tag);
    chk({tag, "_xs"}, 64'(win_xs), 64'(m_xs));
    chk({tag, "_xe"}, 64'(win_xe), 64'(m_xe));
    chk({tag, "_ys"}, 64'(win_ys), 64'(m_ys));
    chk({tag, "_ye"}, 64'(win_ye), 64'(m_ye));
  endtask

  initial begin
    int half, xs, xe, ys, ye, npix, v;
    model_reset();
    tick(5);
    sys_rst = 1'b0;
    tick(100);

    // Reset state and quiet link
    chk("rst_pulses", 64'(n_pulse), 64'(0));
    chk("rst_cmd", 64'(cmd_code), 64'(0));
    chk("rst_pix", 64'({pixel_x, pixel_y, pixel_data}), 64'(0));
    check_win("rst");

    // Window setup
    cs_on();
    send_byte(0, 'h2A, 2);
    send_byte(1, 'h00, 2); send_byte(1, 'h0A, 2);
    send_byte(1, 'h00, 2); send_byte(1, 'h0B, 2);
    send_byte(0, 'h2B, 2);
    send_byte(1, 'h00, 2); send_byte(1, 'h14, 2);
    send_byte(1, 'h00, 2); send_byte(1, 'h15, 2);
    tick(S + 8);
    chk("win_cmds", 64'(n_cmd), 64'(2));
    chk("win_xs_10", 64'(win_xs), 64'(10));
    chk("win_ye_21", 64'(win_ye), 64'(21));
    check_win("win");

    // Four-pixel frame
    send_byte(0, 'h2C, 2);
    send_byte(1, 'hF8, 2); send_byte(1, 'h00, 2);
    send_byte(1, 'h07, 2); send_byte(1, 'hE0, 2);
    send_byte(1, 'h00, 2); send_byte(1, 'h1F, 2);
    send_byte(1, 'hFF, 2); send_byte(1, 'hFF, 2);
    check_pix("frame4");
    chk("frame4_fd", 64'(n_fd), 64'(1));

    // Aborted CASET leaves the window alone
    send_byte(0, 'h2A, 3);
    send_byte(1, 'h00, 3); send_byte(1, 'h05, 3);
    send_byte(0, 'h2C, 3);
    send_byte(1, 'h12, 3); send_byte(1, 'h34, 3);
    send_byte(1, 'h56, 3); send_byte(1, 'h78, 3);
    check_pix("abort");
    check_win("abort");

    // Partial byte then a non-window command
    send_bits(0, 8'hA5, 5, 2);
    cs_off();
    cs_on();
    send_byte(0, 'h36, 2);
    send_byte(1, 'h11, 2); send_byte(1, 'h22, 2);
    check_pix("skip");
    chk("err_partial", 64'(n_err), 64'(1));
    chk("cmd_36", 64'(cmd_code), 64'('h36));

    // Word latency across sclk rates
    lat_q.delete();
    send_byte(0, 'h00, 2);
    send_byte(0, 'h00, 3);
    send_byte(0, 'h00, 7);
    tick(S + 8);
    chk("lat_n", 64'(lat_q.size()), 64'(3));
    foreach (lat_q[i]) chk("lat", 64'(lat_q[i]), 64'(S + 2));

    // Randomised windows, pixel streams and cs toggles
    for (int it = 0; it < 10; it++) begin
      half = $urandom_range(2, 4);
      xs = $urandom_range(0, 511);
      xe = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511)
                                       : xs + $urandom_range(0, 2);
      if (xe > 511) xe = 511;
      ys = $urandom_range(0, 511);
      ye = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511)
                                       : ys + $urandom_range(0, 2);
      if (ye > 511) ye = 511;
      send_byte(0, 'h2A, half);
      send_byte(1, ($urandom_range(0, 127) << 1) | (xs >> 8), half);
      send_byte(1, xs & 255, half);
      send_byte(1, ($urandom_range(0, 127) << 1) | (xe >> 8), half);
      send_byte(1, xe & 255, half);
      if ($urandom_range(0, 1) == 1) begin cs_off(); cs_on(); end
      send_byte(0, 'h2B, half);
      send_byte(1, ys >> 8, half);
      send_byte(1, ys & 255, half);
      send_byte(1, ye >> 8, half);
      send_byte(1, ye & 255, half);
      send_byte(0, 'h2C, half);
      npix = $urandom_range(1, 10);
      for (int p = 0; p < npix; p++) begin
        v = $urandom_range(0, 65535);
        send_byte(1, v >> 8, half);
        if ($urandom_range(0, 3) == 0) begin cs_off(); cs_on(); end
        send_byte(1, v & 255, half);
      end
      if ($urandom_range(0, 1) == 1) send_byte(1, 'hAA, half);
      send_byte(0, 'h00, half);
      send_byte(1, 'h55, half);
      check_pix("rnd");
      check_win("rnd");
    end
    chk("ncmd", 64'(n_cmd), 64'(m_ncmd));
    chk("cmd_last", 64'(cmd_code), 64'(m_cmd));
    chk("nfd", 64'(n_fd), 64'(m_nfd));

    // Reset between HI and LO byte of a pixel
    send_byte(0, 'h2C, 2);
    send_bits(1, 8'hAB, 8, 2);
    tick(S + 4);
    sys_rst = 1'b1;
    model_reset();
    tick(3);
    sys_rst = 1'b0;
    tick(5);
    send_byte(1, 'hCD, 2);
    check_pix("rst_mid");
    check_win("rst_mid");
    chk("rst_mid_cmd", 64'(cmd_code), 64'(0));

    cs_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
